// File: rtl/lab4d_pkg.sv
// Shared definitions for the LAB4D readout sequencer: widths and FSM state encoding.
package lab4d_pkg;

  localparam int LAB4D_ADDR_WIDTH     = 6;
  localparam int LAB4D_PRESCALE_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP      = 3'd1,
    ST_RAMP_WAIT = 3'd2,
    ST_READOUT   = 3'd3,
    ST_CLEAR     = 3'd4
  } lab4d_state_e;

endpackage

// File: rtl/lab4d_addr_fifo.sv
// Small synchronous FIFO of triggered buffer addresses with flush and occupancy count.
// A push while full is dropped even if a pop occurs in the same cycle; flush beats push.
module lab4d_addr_fifo
  import lab4d_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [LAB4D_ADDR_WIDTH-1:0] data_i,
  output logic [LAB4D_ADDR_WIDTH-1:0] data_o,
  output logic [DEPTH_LOG2:0]         count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int                DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  logic [LAB4D_ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0]         cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d = pop_ok  ? rd_q + 1'b1 : rd_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/lab4d_readout_sequencer.sv
// Sequences ramp, readout handshake and buffer release for each queued LAB4D buffer.
// Optional watchdog in RAMP_WAIT/READOUT enabled by defining LAB4D_READOUT_TIMEOUT_EN.
module lab4d_readout_sequencer
  import lab4d_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic                            trig_valid_i,
  input  logic [LAB4D_ADDR_WIDTH-1:0]     trig_addr_i,
  input  logic                            flush_i,
  input  logic [LAB4D_PRESCALE_WIDTH-1:0] readout_prescale_i,
  output logic                            do_ramp_o,
  input  logic                            ramp_done_i,
  output logic                            readout_o,
  output logic [LAB4D_ADDR_WIDTH-1:0]     readout_address_o,
  output logic [LAB4D_PRESCALE_WIDTH-1:0] prescale_o,
  input  logic                            complete_i,
  output logic                            trigger_clear_o,
  output logic                            busy_o,
  output logic [FIFO_DEPTH_LOG2:0]        pending_o,
  output logic                            overflow_o,
  input  logic                            overflow_clr_i,
  output logic                            timeout_o
);

  lab4d_state_e                    state_q, state_d;
  logic                            start, drop, fifo_full, fifo_empty;
  logic                            tmo_hit, tmo_force;
  logic [LAB4D_ADDR_WIDTH-1:0]     fifo_head, addr_q;
  logic [LAB4D_PRESCALE_WIDTH-1:0] prescale_q;
  logic                            do_ramp_q, readout_q, clear_q, busy_q;
  logic                            overflow_q, overflow_d, timeout_q, timeout_d;

  assign start = (state_q == ST_IDLE) && enable_i && !fifo_empty;
  assign drop  = trig_valid_i && fifo_full && !flush_i;

  lab4d_addr_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (trig_valid_i),
    .pop_i   (start),
    .flush_i (flush_i),
    .data_i  (trig_addr_i),
    .data_o  (fifo_head),
    .count_o (pending_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef LAB4D_READOUT_TIMEOUT_EN
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             in_wait;

  assign in_wait = (state_q == ST_RAMP_WAIT) || (state_q == ST_READOUT);
  assign tmo_hit = in_wait && (tmo_cnt_q == TMO_LAST);

  // Counter restarts from zero whenever a wait state is (re)entered.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_wait && (state_d == state_q)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tmo_force = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RAMP;
        else       state_d = ST_IDLE;
      end
      ST_RAMP: state_d = ST_RAMP_WAIT;
      ST_RAMP_WAIT: begin
        if (ramp_done_i) begin
          state_d = ST_READOUT;
        end else if (tmo_hit) begin
          state_d   = ST_CLEAR;
          tmo_force = 1'b1;
        end else begin
          state_d = ST_RAMP_WAIT;
        end
      end
      ST_READOUT: begin
        if (complete_i) begin
          state_d = ST_CLEAR;
        end else if (tmo_hit) begin
          state_d   = ST_CLEAR;
          tmo_force = 1'b1;
        end else begin
          state_d = ST_READOUT;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A new event in the same cycle as a clear request keeps the flag set.
    if (drop)                overflow_d = 1'b1;
    else if (overflow_clr_i) overflow_d = 1'b0;
    else                     overflow_d = overflow_q;

    if (tmo_force)           timeout_d = 1'b1;
    else if (overflow_clr_i) timeout_d = 1'b0;
    else                     timeout_d = timeout_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      do_ramp_q  <= 1'b0;
      readout_q  <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      prescale_q <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      do_ramp_q  <= (state_d == ST_RAMP);
      readout_q  <= (state_d == ST_READOUT);
      clear_q    <= (state_d == ST_CLEAR);
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      if (start) begin
        addr_q     <= fifo_head;
        prescale_q <= readout_prescale_i;
      end
    end
  end

  assign do_ramp_o         = do_ramp_q;
  assign readout_o         = readout_q;
  assign trigger_clear_o   = clear_q;
  assign busy_o            = busy_q;
  assign readout_address_o = addr_q;
  assign prescale_o        = prescale_q;
  assign overflow_o        = overflow_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_lab4d_readout_sequencer.sv
// Scoreboard bench for lab4d_readout_sequencer: directed scenarios followed by random traffic.
module tb_lab4d_readout_sequencer;

  localparam int T_CYC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, trig_valid = 1'b0, flush = 1'b0;
  logic [5:0] trig_addr = 6'd0;
  logic [3:0] prescale = 4'd0;
  logic       ramp_done = 1'b0, complete = 1'b0, ovf_clr = 1'b0;

  logic       do_ramp, readout, trigger_clear, busy, overflow, timeout;
  logic [5:0] readout_address;
  logic [3:0] prescale_out;
  logic [2:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lab4d_readout_sequencer #(
    .FIFO_DEPTH_LOG2(2),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .trig_valid_i       (trig_valid),
    .trig_addr_i        (trig_addr),
    .flush_i            (flush),
    .readout_prescale_i (prescale),
    .do_ramp_o          (do_ramp),
    .ramp_done_i        (ramp_done),
    .readout_o          (readout),
    .readout_address_o  (readout_address),
    .prescale_o         (prescale_out),
    .complete_i         (complete),
    .trigger_clear_o    (trigger_clear),
    .busy_o             (busy),
    .pending_o          (pending),
    .overflow_o         (overflow),
    .overflow_clr_i     (ovf_clr),
    .timeout_o          (timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 ramp pulse, 2 waiting for ramp, 3 readout, 4 release.
  int         ph = 0;
  logic [5:0] pend[$];
  logic [9:0] exp_q[$];
  bit         m_ovf = 1'b0, m_tmo = 1'b0;
  int         m_tcnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; pend.delete(); exp_q.delete(); m_ovf = 1'b0; m_tmo = 1'b0; m_tcnt = 0;
    end else begin : mdl
      int nph;
      bit full, start, forced;
      full   = (pend.size() == 4);
      start  = (ph == 0) && enable && (pend.size() > 0);
      forced = 1'b0;
      nph    = ph;
      if (ph == 0 && start)          nph = 1;
      else if (ph == 1)              nph = 2;
      else if (ph == 2 && ramp_done) nph = 3;
      else if (ph == 3 && complete)  nph = 4;
      else if (ph == 4)              nph = 0;
`ifdef LAB4D_READOUT_TIMEOUT_EN
      if ((ph == 2 || ph == 3) && nph == ph && m_tcnt == T_CYC - 1) begin
        nph = 4; forced = 1'b1;
      end
      m_tcnt = ((ph == 2 || ph == 3) && nph == ph) ? m_tcnt + 1 : 0;
`endif
      if (start) begin
        exp_q.push_back({pend[0], prescale});
        void'(pend.pop_front());
      end
      if (flush)                     pend.delete();
      else if (trig_valid && !full)  pend.push_back(trig_addr);
      if (trig_valid && full && !flush) m_ovf = 1'b1;
      else if (ovf_clr)                 m_ovf = 1'b0;
      if (forced)       m_tmo = 1'b1;
      else if (ovf_clr) m_tmo = 1'b0;
      ph = nph;
    end
  end

  // Monitor: per-cycle outputs against the model, sequence transactions against the queue.
  logic [9:0] exp_e;
  logic [5:0] cur_addr = 6'd0;
  always @(negedge clk) begin
    chk("pending", pending, pend.size());
    chk("busy", busy, (ph != 0));
    chk("do_ramp", do_ramp, (ph == 1));
    chk("readout", readout, (ph == 3));
    chk("trigger_clear", trigger_clear, (ph == 4));
    chk("overflow", overflow, m_ovf);
    chk("timeout", timeout, m_tmo);
    if (do_ramp) begin
      chk("ramp_txn_avail", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        chk("ramp_addr", readout_address, exp_e[9:4]);
        chk("ramp_prescale", prescale_out, exp_e[3:0]);
        cur_addr = exp_e[9:4];
      end
    end
    if (trigger_clear) chk("clear_addr", readout_address, cur_addr);
  end

  task automatic push_trig(input logic [5:0] a);
    @(negedge clk); trig_valid = 1'b1; trig_addr = a;
    @(negedge clk); trig_valid = 1'b0;
  endtask

  task automatic wait_ramp();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = do_ramp;
    end
    chk("do_ramp_seen", seen, 1);
  endtask

  task automatic finish_seq(input int d1, input int d2);
    repeat (d1) @(negedge clk);
    ramp_done = 1'b1;
    @(negedge clk); ramp_done = 1'b0;
    repeat (d2) @(negedge clk);
    complete = 1'b1;
    @(negedge clk); complete = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single trigger 0x2A with explicit timing points.
    enable = 1'b1;
    push_trig(6'h2A);
    wait_ramp();
    repeat (10) @(negedge clk);
    ramp_done = 1'b1;
    @(negedge clk); ramp_done = 1'b0;
    chk("t1_readout", readout, 1);
    chk("t1_addr", readout_address, 6'h2A);
    repeat (2) @(negedge clk);
    complete = 1'b1;
    @(negedge clk); complete = 1'b0;
    chk("t1_clear", trigger_clear, 1);
    @(negedge clk);
    chk("t1_busy_low", busy, 0);

    // Three queued buffers, served in order.
    enable = 1'b0;
    push_trig(6'h01); push_trig(6'h02); push_trig(6'h03);
    chk("t2_pending3", pending, 3);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ramp();
      finish_seq(1 + k, 2);
    end
    repeat (4) @(negedge clk);

    // Overflow: five pushes into a four-deep queue, then push coincident with pop.
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); trig_valid = 1'b1; trig_addr = 6'(8'h10 + k);
    end
    @(negedge clk); trig_valid = 1'b0;
    @(negedge clk);
    chk("t3_pending4", pending, 4);
    chk("t3_overflow", overflow, 1);
    enable = 1'b1; trig_valid = 1'b1; trig_addr = 6'h3F;
    @(negedge clk); enable = 1'b0; trig_valid = 1'b0;
    @(negedge clk);
    chk("t3_pending_after_pop", pending, 3);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    @(negedge clk);
    chk("t3_overflow_cleared", overflow, 0);
    finish_seq(1, 1);

    // enable dropped during READOUT: sequence completes, queue untouched.
    enable = 1'b1;
    wait_ramp();
    @(negedge clk); ramp_done = 1'b1;
    @(negedge clk); ramp_done = 1'b0; enable = 1'b0;
    @(negedge clk); complete = 1'b1;
    @(negedge clk); complete = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_pending2", pending, 2);
    chk("t4_idle", busy, 0);
    enable = 1'b1;
    wait_ramp(); finish_seq(2, 2);
    wait_ramp(); finish_seq(1, 1);
    repeat (4) @(negedge clk);

    // Asynchronous reset while waiting for the ramp.
    enable = 1'b0;
    push_trig(6'h15); push_trig(6'h16);
    enable = 1'b1;
    wait_ramp();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_do_ramp", do_ramp, 0);
    chk("rst_readout", readout, 0);
    chk("rst_clear", trigger_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_addr", readout_address, 0);
    chk("rst_prescale", prescale_out, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // Ramp never finishes: watchdog releases the buffer only when enabled.
    push_trig(6'h2B);
    wait_ramp();
    repeat (40) @(negedge clk);
`ifdef LAB4D_READOUT_TIMEOUT_EN
    chk("t6_busy", busy, 0);
    chk("t6_timeout", timeout, 1);
`else
    chk("t6_busy", busy, 1);
    chk("t6_timeout", timeout, 0);
`endif
    finish_seq(1, 1);
    repeat (4) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      trig_valid = ($urandom_range(2) == 0);
      trig_addr  = 6'($urandom_range(63));
      prescale   = 4'($urandom_range(15));
      flush      = ($urandom_range(39) == 0);
      ovf_clr    = ($urandom_range(15) == 0);
      ramp_done  = ($urandom_range(3) == 0);
      complete   = ($urandom_range(3) == 0);
      if ($urandom_range(29) == 0) enable = ~enable;
    end
    @(negedge clk);
    trig_valid = 1'b0; flush = 1'b0; ovf_clr = 1'b0; enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ramp_done = ($urandom_range(3) == 0);
      complete  = ($urandom_range(3) == 0);
    end
    ramp_done = 1'b0; complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("txn_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
